// File: rtl/uart_tx_port.sv
// uart_tx_port: CPU output-port UART transmitter.
// A byte written with a one-cycle wr_en strobe is queued in a small circular
// FIFO and shifted out LSB first on tx (8N1). The status byte exposes
// {count, overflow, busy, full, empty} for software polling.
// Optional feature: define UART_TX_PARITY_EN to insert an even parity bit
// between the data bits and the stop bit (11-bit frame).
module uart_tx_port #(
  parameter int CLKS_PER_BIT = 4,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] wr_data,
  input  logic       wr_en,
  output logic [7:0] status,
  output logic       tx
);

  localparam int DATA_W = 8;
  localparam int BAUD_W = $clog2(CLKS_PER_BIT);
  localparam int PTR_W  = $clog2(FIFO_DEPTH);
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [3:0]        DEPTH_CNT = 4'(FIFO_DEPTH);

`ifdef UART_TX_PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
`endif

  logic [DATA_W-1:0] mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [3:0]        count;
  logic              overflow;

  state_t            state;
  logic [BAUD_W-1:0] baud_cnt;
  logic [2:0]        bit_idx;
  logic [DATA_W-1:0] shift_p0;
`ifdef UART_TX_PARITY_EN
  logic              parity_p0;
`endif

  logic empty;
  logic full;
  logic baud_wrap;
  logic push;
  logic pop;

  assign empty     = (count == 4'd0);
  assign full      = (count == DEPTH_CNT);
  assign baud_wrap = (baud_cnt == BAUD_LAST);
  // A write while full is dropped even when the FSM frees a slot on the same edge.
  assign push      = wr_en && !full;
  assign pop       = !empty && ((state == IDLE) || ((state == STOP) && baud_wrap));

  assign status = {count, overflow, (state != IDLE), full, empty};

  // FIFO storage: data only, no reset needed.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wr_data;
  end

  // FIFO pointers, occupancy and sticky overflow flag.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= 4'd0;
      overflow <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + 4'd1;
        2'b01:   count <= count - 4'd1;
        default: count <= count;
      endcase
      if (wr_en && full) overflow <= 1'b1;
    end
  end

  // Shift register: loaded on pop, shifted right on each data-bit boundary.
  always_ff @(posedge clk) begin
    if (pop) begin
      shift_p0  <= mem[rd_ptr];
`ifdef UART_TX_PARITY_EN
      parity_p0 <= ^mem[rd_ptr];
`endif
    end else if ((state == DATA) && baud_wrap) begin
      shift_p0  <= {1'b0, shift_p0[DATA_W-1:1]};
    end
  end

  // Frame sequencer; tx is registered and always set to the level of the bit being entered.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      baud_cnt <= '0;
      bit_idx  <= 3'd0;
      tx       <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          baud_cnt <= '0;
          tx       <= 1'b1;
          if (pop) begin
            state <= START;
            tx    <= 1'b0;
          end
        end
        START: begin
          if (baud_wrap) begin
            baud_cnt <= '0;
            bit_idx  <= 3'd0;
            state    <= DATA;
            tx       <= shift_p0[0];
          end else begin
            baud_cnt <= baud_cnt + BAUD_W'(1);
          end
        end
        DATA: begin
          if (baud_wrap) begin
            baud_cnt <= '0;
            if (bit_idx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
              state <= PARITY;
              tx    <= parity_p0;
`else
              state <= STOP;
              tx    <= 1'b1;
`endif
            end else begin
              bit_idx <= bit_idx + 3'd1;
              tx      <= shift_p0[1];
            end
          end else begin
            baud_cnt <= baud_cnt + BAUD_W'(1);
          end
        end
`ifdef UART_TX_PARITY_EN
        PARITY: begin
          if (baud_wrap) begin
            baud_cnt <= '0;
            state    <= STOP;
            tx       <= 1'b1;
          end else begin
            baud_cnt <= baud_cnt + BAUD_W'(1);
          end
        end
`endif
        STOP: begin
          if (baud_wrap) begin
            baud_cnt <= '0;
            // Next queued byte starts immediately, with no idle gap.
            if (pop) begin
              state <= START;
              tx    <= 1'b0;
            end else begin
              state <= IDLE;
              tx    <= 1'b1;
            end
          end else begin
            baud_cnt <= baud_cnt + BAUD_W'(1);
          end
        end
        default: begin
          state    <= IDLE;
          baud_cnt <= '0;
          tx       <= 1'b1;
        end
      endcase
    end
  end

endmodule
